// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
// Shared definitions for the digit-serial add/subtract engine.
//   DIGIT_W : width of the ripple slice processed per cycle
//   state_t : control FSM states (IDLE -> RUN -> DONE)
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_digit.sv
// -----------------------------------------------------------------------------
// addsub_digit
// Purely combinational DIGIT_W-bit ripple adder slice. The operand B is
// expected to be pre-inverted by the caller for subtraction.
// Ports:
//   a, bx : digit operands
//   cin   : carry into bit 0
//   s     : digit sum
//   cout  : carry out of the top bit
//   c3    : carry into the top bit (used for signed overflow detection)
// -----------------------------------------------------------------------------
module addsub_digit
    import serial_addsub_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] bx,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout,
    output logic               c3
);

    logic [DIGIT_W:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_bit
        assign s[gi]    = a[gi] ^ bx[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & bx[gi]) | (c[gi] & (a[gi] ^ bx[gi]));
    end

    assign cout = c[DIGIT_W];
    assign c3   = c[DIGIT_W-1];

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Multi-cycle WIDTH-bit add/subtract engine. Operands are accepted over a
// valid/ready handshake, processed one 4-bit digit per cycle through a single
// addsub_digit slice (carry held in a flop between digits), and the result is
// held on s/co until the downstream handshake completes.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, sub, ci)
//   sub                 : 0 = a+b+ci, 1 = a-b-ci (ci acts as borrow-in)
//   out_valid/out_ready : result handshake (s, co[, ovf])
//   co                  : raw carry-out; for subtract 1 means no borrow
//   ovf                 : signed overflow, present only when the macro
//                         SERIAL_ADDSUB_OVF_EN is defined
//
// Latency from accepting edge to out_valid is NDIG cycles; peak throughput is
// one result every NDIG+2 cycles.
// -----------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    if (WIDTH < DIGIT_W || (WIDTH % DIGIT_W) != 0) begin : g_bad_width
        $error("serial_addsub: WIDTH must be a positive multiple of 4");
    end

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   bx_q,        bx_d;
    logic               carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   s_q,         s_d;
    logic               co_q,        co_d;
    logic               out_valid_q, out_valid_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q,       ovf_d;
`endif

    logic [DIGIT_W-1:0] dig_s;
    logic               dig_cout;
    logic               dig_c3;

    addsub_digit u_digit (
        .a    (a_q[DIGIT_W-1:0]),
        .bx   (bx_q[DIGIT_W-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout),
        .c3   (dig_c3)
    );

`ifndef SERIAL_ADDSUB_OVF_EN
    // The carry into the MSB only matters for overflow detection.
    logic c3_unused;
    assign c3_unused = dig_c3;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        bx_d        = bx_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        co_d        = co_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d       = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // B is stored already inverted for subtract, and the
                    // inversion of ci turns borrow-in into the two's
                    // complement +1.
                    a_d     = a;
                    bx_d    = b ^ {WIDTH{sub}};
                    carry_d = ci ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Result digits enter at the MSB end so that after NDIG
                // shifts digit 0 has arrived at the bottom.
                s_d     = WIDTH'({dig_s, s_q} >> DIGIT_W);
                carry_d = dig_cout;
                a_d     = a_q  >> DIGIT_W;
                bx_d    = bx_q >> DIGIT_W;
                if (cnt_q == LAST_DIG) begin
                    cnt_d       = '0;
                    co_d        = dig_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d       = dig_cout ^ dig_c3;
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            bx_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            s_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            bx_q        <= bx_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Gated by rst_n so no operation is offered while reset is asserted.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
// Directed bench for serial_addsub (WIDTH=16). Expected results come from a
// full-width arithmetic model, are queued at acceptance and compared when
// the DUT presents them. Overflow checks are active when
// SERIAL_ADDSUB_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;
`endif

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    function automatic exp_t model(logic [WIDTH-1:0] fa, logic [WIDTH-1:0] fb,
                                   logic fsub, logic fci);
        exp_t             e;
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   full;
        bx    = fsub ? ~fb : fb;
        full  = {1'b0, fa} + {1'b0, bx} + {{WIDTH{1'b0}}, fci ^ fsub};
        e.s   = full[WIDTH-1:0];
        e.co  = full[WIDTH];
        e.ovf = (fa[WIDTH-1] == bx[WIDTH-1]) && (e.s[WIDTH-1] != fa[WIDTH-1]);
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic compare_result(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_s"}, 32'(s), 32'(e.s));
            check({tag, "_co"}, 32'(co), 32'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    // Offers one operation, checks latency and result; optionally completes
    // the output handshake.
    task automatic do_op(string tag, logic [WIDTH-1:0] oa, logic [WIDTH-1:0] ob,
                         logic osub, logic oci, bit handshake);
        int waitc;
        a = oa; b = ob; sub = osub; ci = oci; in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        sb.push_back(model(oa, ob, osub, oci));
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        waitc = 0;
        while (!out_valid && waitc < 20) begin
            tick();
            waitc++;
        end
        check({tag, "_latency"}, 32'(waitc), 32'd4);
        $display("[TB] %s a=%h b=%h sub=%0d ci=%0d -> s=%h co=%0d", tag, oa, ob,
                 osub, oci, s, co);
        compare_result(tag);
        if (handshake) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [WIDTH-1:0] held_s;
        logic             held_co;
        logic [WIDTH-1:0] ta [4];
        logic [WIDTH-1:0] tb [4];
        logic             tsub [4];
        int               acc_cyc [4];
        int               idx;
        int               nres;
        int               guard;
        bit               acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; ci = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // 1-3: basic add, carry/overflow, subtract with borrow
        do_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        do_op("add_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b1);
        do_op("sub_bin",    16'h0010, 16'h0001, 1'b1, 1'b1, 1'b1);
        do_op("add_cin",    16'h0FFF, 16'h0000, 1'b0, 1'b1, 1'b1);

        // 4: stall in DONE while new operands are offered
        do_op("stall", 16'hA5A5, 16'h1111, 1'b0, 1'b0, 1'b0);
        held_s  = s;
        held_co = co;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = $urandom; b = $urandom; sub = $urandom; ci = $urandom;
            tick();
            check("stall_s", 32'(s), 32'(held_s));
            check("stall_co", 32'(co), 32'(held_co));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_release_ovalid", 32'(out_valid), 32'd0);
        check("stall_release_iready", 32'(in_ready), 32'd1);
        do_op("after_stall", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);

        // 5: back-to-back operations
        ta[0] = 16'h0001; tb[0] = 16'h0002; tsub[0] = 1'b0;
        ta[1] = 16'hBEEF; tb[1] = 16'h1234; tsub[1] = 1'b1;
        ta[2] = 16'h8000; tb[2] = 16'h0001; tsub[2] = 1'b1;
        ta[3] = 16'hF0F0; tb[3] = 16'h0F0F; tsub[3] = 1'b0;
        idx = 0; nres = 0; guard = 0;
        a = ta[0]; b = tb[0]; sub = tsub[0]; ci = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (nres < 4 && guard < 100) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                $display("[TB] b2b result %0d s=%h co=%0d", nres, s, co);
                compare_result("b2b");
                nres++;
            end
            if (acc) begin
                acc_cyc[idx] = cyc;
                sb.push_back(model(a, b, sub, ci));
            end
            tick();
            guard++;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    a = ta[idx]; b = tb[idx]; sub = tsub[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_done", 32'(nres), 32'd4);
        for (int i = 1; i < 4; i++)
            check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        // 6: reset in the middle of RUN
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; ci = 1'b1; in_valid = 1'b1;
        check("midrst_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_iready_low", 32'(in_ready), 32'd0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_co", 32'(co), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_iready_rel", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end
        do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
